// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional-unit requesters and the CDB broadcast arbiter.
// The master side drives requests; the slave side (the arbiter) drives grants and both buses.
interface cdb_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 64
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    grant;
  logic [DW-1:0]      cdb_data;
  logic               cdb_write;
  logic [DW-1:0]      cdb_data2;
  logic               cdb_write2;

  modport master (
    output req, req_data,
    input  grant, cdb_data, cdb_write, cdb_data2, cdb_write2
  );

  modport slave (
    input  req, req_data,
    output grant, cdb_data, cdb_write, cdb_data2, cdb_write2
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that places up to two requester words per cycle onto the two CDB ports.
// Each bus runs FREE -> PULSE -> FREE so that every write strobe is one cycle high, then low.
module cdb_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 64,
  parameter int PW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  cdb
);

  typedef enum logic {FREE, PULSE} bus_state_e;

  bus_state_e      bus0_q, bus0_d;
  bus_state_e      bus1_q, bus1_d;
  logic [DW-1:0]   data0_q, data0_d;
  logic [DW-1:0]   data1_q, data1_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0] eligible;
  logic            avail0, avail1;
  logic            win0, win1;
  int              idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus0_q   <= FREE;
      bus1_q   <= FREE;
      data0_q  <= '0;
      data1_q  <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      bus0_q   <= bus0_d;
      bus1_q   <= bus1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Requesters granted last cycle still hold req high, so they are masked out here.
  always_comb begin
    eligible = cdb.req & ~grant_q;
    avail0   = (bus0_q == FREE);
    avail1   = (bus1_q == FREE);
    win0     = 1'b0;
    win1     = 1'b0;
    idx      = 0;
    grant_d  = '0;
    data0_d  = data0_q;
    data1_d  = data1_q;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NREQ;
      if (eligible[idx]) begin
        if (avail0) begin
          avail0       = 1'b0;
          win0         = 1'b1;
          data0_d      = cdb.req_data[idx*DW +: DW];
          grant_d[idx] = 1'b1;
          rr_ptr_d     = PW'((idx + 1) % NREQ);
        end else if (avail1) begin
          avail1       = 1'b0;
          win1         = 1'b1;
          data1_d      = cdb.req_data[idx*DW +: DW];
          grant_d[idx] = 1'b1;
          rr_ptr_d     = PW'((idx + 1) % NREQ);
        end
      end
    end

    case (bus0_q)
      FREE:    bus0_d = win0 ? PULSE : FREE;
      default: bus0_d = FREE;
    endcase
    case (bus1_q)
      FREE:    bus1_d = win1 ? PULSE : FREE;
      default: bus1_d = FREE;
    endcase
  end

  always_comb begin
    cdb.cdb_write  = (bus0_q == PULSE);
    cdb.cdb_write2 = (bus1_q == PULSE);
    cdb.cdb_data   = data0_q;
    cdb.cdb_data2  = data1_q;
    cdb.grant      = grant_q;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized checks of cdb_arbiter against a queue-based model of the
// round-robin, two-bus broadcast rules.
module tb_cdb_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 64;

  logic clk = 1'b0;
  logic rst;

  cdb_arbiter_if #(.NREQ(NREQ), .DW(DW)) cif ();

  cdb_arbiter #(.NREQ(NREQ), .DW(DW), .PW(2)) dut (
    .clk (clk),
    .rst (rst),
    .cdb (cif)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Model state: bus busy flags, held bus words, grant vector and pointer.
  logic [NREQ-1:0] m_grant;
  logic            m_w0, m_w1;
  logic [DW-1:0]   m_d0, m_d1;
  int              m_rr;

  task automatic modelStep(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*DW-1:0] d);
    int cand[$];
    int buses[$];
    int n, last, u;
    logic [NREQ-1:0] g;
    logic nw0, nw1;
    if (r) begin
      m_grant = '0; m_w0 = 1'b0; m_w1 = 1'b0; m_d0 = '0; m_d1 = '0; m_rr = 0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        u = (m_rr + k) % NREQ;
        if (rq[u] && !m_grant[u]) cand.push_back(u);
      end
      if (!m_w0) buses.push_back(0);
      if (!m_w1) buses.push_back(1);
      n = (cand.size() < buses.size()) ? cand.size() : buses.size();
      g = '0; nw0 = 1'b0; nw1 = 1'b0; last = -1;
      for (int j = 0; j < n; j++) begin
        g[cand[j]] = 1'b1;
        last = cand[j];
        if (buses[j] == 0) begin nw0 = 1'b1; m_d0 = d[cand[j]*DW +: DW]; end
        else               begin nw1 = 1'b1; m_d1 = d[cand[j]*DW +: DW]; end
      end
      if (last >= 0) m_rr = (last + 1) % NREQ;
      m_grant = g; m_w0 = nw0; m_w1 = nw1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*DW-1:0] d);
    rst          = r;
    cif.req      = rq;
    cif.req_data = d;
    @(posedge clk);
    modelStep(r, rq, d);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " grant"},  64'(cif.grant),      64'(m_grant));
    checkOutput({tag, " write"},  64'(cif.cdb_write),  64'(m_w0));
    checkOutput({tag, " write2"}, 64'(cif.cdb_write2), 64'(m_w1));
    checkOutput({tag, " data"},   cif.cdb_data,        m_d0);
    checkOutput({tag, " data2"},  cif.cdb_data2,       m_d1);
  endtask

  task automatic doReset(input logic [NREQ-1:0] rq, input logic [NREQ*DW-1:0] d);
    applyStimulus(1'b1, rq, d);
    applyStimulus(1'b1, rq, d);
    checkAll("reset");
    checkOutput("reset grant0",  64'(cif.grant), 64'd0);
    checkOutput("reset data0",   cif.cdb_data,   64'd0);
    checkOutput("reset write0",  64'(cif.cdb_write | cif.cdb_write2), 64'd0);
  endtask

  logic [NREQ*DW-1:0] dv;
  logic [NREQ-1:0]    rq;
  logic [NREQ-1:0]    pend;
  logic [DW-1:0]      w;

  initial begin
    rst = 1'b1; cif.req = '0; cif.req_data = '0;
    m_grant = '0; m_w0 = 1'b0; m_w1 = 1'b0; m_d0 = '0; m_d1 = '0; m_rr = 0;
    for (int i = 0; i < NREQ; i++) dv[i*DW +: DW] = 64'h1000_0000_0000_0000 * (i + 1) + 64'(i);

    // Reset with all requesting, then fairness with data refreshed after each grant.
    doReset(4'b1111, dv);
    applyStimulus(1'b0, 4'b1111, dv);
    checkAll("fair c1");
    checkOutput("fair c1 grant", 64'(cif.grant), 64'h3);
    checkOutput("fair c1 data",  cif.cdb_data,  dv[0 +: DW]);
    checkOutput("fair c1 data2", cif.cdb_data2, dv[DW +: DW]);
    applyStimulus(1'b0, 4'b1111, dv);
    checkAll("fair c2");
    checkOutput("fair c2 strobes", 64'({cif.cdb_write, cif.cdb_write2}), 64'd0);
    dv[0 +: DW]  = 64'hAAAA_0000_0000_0001;
    dv[DW +: DW] = 64'hBBBB_0000_0000_0002;
    applyStimulus(1'b0, 4'b1111, dv);
    checkAll("fair c3");
    checkOutput("fair c3 grant", 64'(cif.grant), 64'hC);
    applyStimulus(1'b0, 4'b1111, dv);
    checkAll("fair c4");
    dv[2*DW +: DW] = 64'hCCCC_0000_0000_0003;
    dv[3*DW +: DW] = 64'hDDDD_0000_0000_0004;
    applyStimulus(1'b0, 4'b1111, dv);
    checkAll("fair c5");
    checkOutput("fair c5 grant", 64'(cif.grant), 64'h3);
    checkOutput("fair c5 data",  cif.cdb_data, 64'hAAAA_0000_0000_0001);

    // Single request on unit 2.
    doReset(4'b0000, dv);
    dv[2*DW +: DW] = 64'h0005_0000_0000_002A;
    applyStimulus(1'b0, 4'b0100, dv);
    checkAll("single c1");
    checkOutput("single grant", 64'(cif.grant), 64'h4);
    checkOutput("single data",  cif.cdb_data,   64'h0005_0000_0000_002A);
    checkOutput("single write2", 64'(cif.cdb_write2), 64'd0);
    applyStimulus(1'b0, 4'b0000, dv);
    checkAll("single c2");
    checkOutput("single hold data", cif.cdb_data, 64'h0005_0000_0000_002A);

    // Dual issue, then pointer at 2 puts unit 2 ahead of unit 0.
    doReset(4'b0000, dv);
    applyStimulus(1'b0, 4'b0011, dv);
    checkAll("dual c1");
    checkOutput("dual grant", 64'(cif.grant), 64'h3);
    applyStimulus(1'b0, 4'b0011, dv);
    checkAll("dual c2");
    applyStimulus(1'b0, 4'b0101, dv);
    checkAll("dual rr");
    checkOutput("dual rr data",  cif.cdb_data,  dv[2*DW +: DW]);
    checkOutput("dual rr data2", cif.cdb_data2, dv[0 +: DW]);

    // Masking: unit 0 still high during its grant; unit 1 lands on bus 1.
    doReset(4'b0000, dv);
    applyStimulus(1'b0, 4'b0001, dv);
    checkAll("mask c1");
    applyStimulus(1'b0, 4'b0011, dv);
    checkAll("mask c2");
    checkOutput("mask grant", 64'(cif.grant), 64'h2);
    checkOutput("mask strobes", 64'({cif.cdb_write, cif.cdb_write2}), 64'h1);
    checkOutput("mask data2", cif.cdb_data2, dv[DW +: DW]);
    applyStimulus(1'b0, 4'b0000, dv);
    checkAll("mask c3");

    // Reset while bus 0 strobes; pending unit 1 is arbitrated afterwards onto bus 0.
    doReset(4'b0000, dv);
    applyStimulus(1'b0, 4'b0001, dv);
    checkOutput("midrst pre write", 64'(cif.cdb_write), 64'd1);
    applyStimulus(1'b1, 4'b0010, dv);
    checkAll("midrst rst");
    checkOutput("midrst write", 64'(cif.cdb_write), 64'd0);
    checkOutput("midrst grant", 64'(cif.grant), 64'd0);
    applyStimulus(1'b0, 4'b0010, dv);
    checkAll("midrst rearb");
    checkOutput("midrst rearb grant", 64'(cif.grant), 64'h2);
    checkOutput("midrst rearb data",  cif.cdb_data, dv[DW +: DW]);

    // Randomized requesters obeying the hold-until-granted protocol.
    doReset(4'b0000, dv);
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_grant[i]) begin
          rq[i]   = 1'b1;
          pend[i] = 1'b0;
        end else begin
          if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
            pend[i] = 1'b1;
            w = {$urandom, $urandom};
            dv[i*DW +: DW] = w;
          end
          rq[i] = pend[i];
        end
      end
      applyStimulus(($urandom_range(0, 49) == 0), rq, dv);
      checkAll("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
